read_scheduler: RTL and testbench

//  Packet-granular egress scheduler for one output port of the SRAM buffer. Picks which of
//  num_of_queues priority queues sends its next packet, by strict priority or weighted round robin.

---
 rtl/read_scheduler.sv | 117 +++++++++++
 tb/tb_read_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_scheduler.sv
// Egress packet scheduler: strict priority or weighted round robin over num_of_queues queues.
// Ports: clk, rst (async active-low), sp0_wrr1 mode, q_nonempty/q_weight_p queue status,
//        dq_ready/dq_eop read-datapath handshake, grant_vld/grant_id/busy grant outputs.
module read_scheduler #(
    parameter int num_of_queues = 8,
    parameter int weight_width  = 4,
    parameter int id_width      = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  sp0_wrr1,
    input  logic [num_of_queues-1:0]              q_nonempty,
    input  logic [num_of_queues*weight_width-1:0] q_weight_p,
    input  logic                                  dq_ready,
    input  logic                                  dq_eop,
    output logic                                  grant_vld,
    output logic [id_width-1:0]                   grant_id,
    output logic                                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        RELOAD,
        GRANT,
        XFER
    } state_t;

    state_t                  state;
    logic [id_width-1:0]     rr_ptr;
    logic [weight_width-1:0] credit [num_of_queues];
    logic [weight_width-1:0] weight [num_of_queues];

    logic [num_of_queues-1:0] has_credit;
    logic [num_of_queues-1:0] has_weight;
    logic [num_of_queues-1:0] eligible;
    logic                     found;
    logic [id_width-1:0]      winner;
    logic [id_width-1:0]      winner_next;
    logic                     need_reload;

    always_comb begin
        for (int i = 0; i < num_of_queues; i++) begin
            weight[i]     = q_weight_p[i*weight_width +: weight_width];
            has_credit[i] = (credit[i] != '0);
            has_weight[i] = (weight[i] != '0);
        end
    end

    // Descending loops let the last hit (lowest index / closest to rr_ptr) win.
    always_comb begin
        eligible = sp0_wrr1 ? (q_nonempty & has_credit) : q_nonempty;
        found    = 1'b0;
        winner   = '0;
        if (!sp0_wrr1) begin
            for (int i = num_of_queues - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    found  = 1'b1;
                    winner = id_width'(i);
                end
            end
        end else begin
            for (int k = num_of_queues - 1; k >= 0; k--) begin
                if (eligible[(int'(rr_ptr) + k) % num_of_queues]) begin
                    found  = 1'b1;
                    winner = id_width'((int'(rr_ptr) + k) % num_of_queues);
                end
            end
        end
        need_reload = sp0_wrr1 && !found && |(q_nonempty & has_weight);
        winner_next = (winner == id_width'(num_of_queues - 1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_vld <= 1'b0;
            grant_id  <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < num_of_queues; i++) credit[i] <= '0;
        end else begin
            grant_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found && dq_ready) begin
                        grant_id  <= winner;
                        grant_vld <= 1'b1;
                        busy      <= 1'b1;
                        state     <= GRANT;
                        // Winner is eligible only with credit >= 1, so no wrap.
                        if (sp0_wrr1) begin
                            credit[winner] <= credit[winner] - weight_width'(1);
                            rr_ptr         <= winner_next;
                        end
                    end else if (need_reload) begin
                        state <= RELOAD;
                    end
                end
                RELOAD: begin
                    for (int i = 0; i < num_of_queues; i++) credit[i] <= weight[i];
                    state <= IDLE;
                end
                GRANT: begin
                    state <= XFER;
                end
                XFER: begin
                    if (dq_eop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_scheduler.sv
// Self-checking bench for read_scheduler: SP table, WRR rounds, backpressure,
// stray eop / mode switch, pointer wrap and reset mid-transfer.
module tb_read_scheduler;

    localparam int NQ = 8;
    localparam int WW = 4;
    localparam int IW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sp0_wrr1 = 1'b0;
    logic [NQ-1:0]    q_nonempty = '0;
    logic [NQ*WW-1:0] q_weight_p = '0;
    logic             dq_ready = 1'b0;
    logic             dq_eop;
    logic             grant_vld;
    logic [IW-1:0]    grant_id;
    logic             busy;

    logic auto_en = 1'b1;
    logic auto_pulse = 1'b0;
    logic man_eop = 1'b0;
    int   eop_cnt = 0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [IW-1:0] exp_q[$];
    int            stamp_q[$];

    typedef struct {
        logic [NQ-1:0] ne;
        int            n;
        logic [IW-1:0] id;
    } sp_vec_t;

    sp_vec_t       sp_tab[5];
    logic [IW-1:0] wrr_exp[12];

    assign dq_eop = auto_pulse | man_eop;

    read_scheduler #(
        .num_of_queues(NQ),
        .weight_width (WW),
        .id_width     (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sp0_wrr1  (sp0_wrr1),
        .q_nonempty(q_nonempty),
        .q_weight_p(q_weight_p),
        .dq_ready  (dq_ready),
        .dq_eop    (dq_eop),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Scoreboard: every grant pops one expected id.
    always @(posedge clk) begin
        #1;
        if (grant_vld) begin
            stamp_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_grant: got id %0d, none expected", grant_id);
            end else begin
                check("grant_id", int'(grant_id), int'(exp_q.pop_front()));
            end
        end
    end

    // Auto end-of-packet: eop sampled on the second XFER edge.
    always @(negedge clk) begin
        auto_pulse = 1'b0;
        if (eop_cnt != 0) begin
            eop_cnt--;
            if (eop_cnt == 0) auto_pulse = 1'b1;
        end
        if (grant_vld && auto_en) eop_cnt = 2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        dq_ready = 1'b0;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: timeout, %0d grants pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_w(input int q, input int w);
        q_weight_p[q*WW +: WW] = WW'(w);
    endtask

    task automatic gap(input string name, input int i, input int want);
        if (stamp_q.size() > i + 1)
            check(name, stamp_q[i+1] - stamp_q[i], want);
        else
            check({name, "_count"}, stamp_q.size(), i + 2);
    endtask

    initial begin
        sp_tab[0] = '{ne: 8'hA4, n: 3, id: 3'd2};
        sp_tab[1] = '{ne: 8'hA0, n: 2, id: 3'd5};
        sp_tab[2] = '{ne: 8'h80, n: 2, id: 3'd7};
        sp_tab[3] = '{ne: 8'h01, n: 1, id: 3'd0};
        sp_tab[4] = '{ne: 8'hFE, n: 2, id: 3'd1};
        wrr_exp = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd2, 3'd0,
                    3'd1, 3'd2, 3'd0, 3'd2, 3'd0, 3'd0};

        #2 rst = 1'b0;
        cycles(3);
        check("rst_grant_vld", grant_vld, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        cycles(2);

        // Strict priority table
        for (int v = 0; v < 5; v++) begin
            stamp_q.delete();
            q_nonempty = sp_tab[v].ne;
            for (int k = 0; k < sp_tab[v].n; k++) exp_q.push_back(sp_tab[v].id);
            dq_ready = 1'b1;
            drain("sp_table", 60);
            if (sp_tab[v].n > 1) gap("sp_gap", 0, 4);
        end
        cycles(6);

        // WRR: two rounds, each preceded by a reload
        stamp_q.delete();
        set_w(0, 3);
        set_w(1, 1);
        set_w(2, 2);
        sp0_wrr1 = 1'b1;
        q_nonempty = 8'hFF;
        foreach (wrr_exp[i]) exp_q.push_back(wrr_exp[i]);
        dq_ready = 1'b1;
        drain("wrr", 200);
        gap("wrr_gap", 0, 4);
        gap("wrr_reload_gap", 5, 6);
        cycles(6);

        // Backpressure
        sp0_wrr1 = 1'b0;
        q_nonempty = 8'hFF;
        stamp_q.delete();
        cycles(20);
        check("bp_no_grant", stamp_q.size(), 0);
        check("bp_busy", busy, 0);
        exp_q.push_back(3'd0);
        dq_ready = 1'b1;
        @(posedge clk);
        #1 check("bp_latency", grant_vld, 1);
        @(posedge clk);
        #1 check("bp_pulse_end", grant_vld, 0);
        drain("bp", 20);
        cycles(6);

        // Stray eop in IDLE and in GRANT, then mode switch during XFER
        man_eop = 1'b1;
        cycles(1);
        man_eop = 1'b0;
        cycles(2);
        check("eop_idle_busy", busy, 0);
        auto_en = 1'b0;
        q_nonempty = 8'h05;
        exp_q.push_back(3'd0);
        dq_ready = 1'b1;
        drain("mode_sp", 20);
        man_eop = 1'b1;
        cycles(1);
        man_eop = 1'b0;
        cycles(3);
        check("eop_grant_ignored", busy, 1);
        sp0_wrr1 = 1'b1;
        cycles(2);
        check("mode_hold_id", grant_id, 0);
        check("mode_hold_busy", busy, 1);
        exp_q.push_back(3'd2);
        dq_ready = 1'b1;
        man_eop = 1'b1;
        cycles(1);
        man_eop = 1'b0;
        drain("mode_wrr", 20);
        cycles(1);
        man_eop = 1'b1;
        cycles(1);
        man_eop = 1'b0;
        cycles(2);
        check("eop_done_busy", busy, 0);
        auto_en = 1'b1;

        // Pointer wrap: park rr_ptr at 7 via a q6 grant
        q_weight_p = '0;
        set_w(6, 1);
        set_w(7, 1);
        set_w(0, 1);
        q_nonempty = 8'h40;
        exp_q.push_back(3'd6);
        dq_ready = 1'b1;
        drain("wrap_park", 30);
        cycles(6);
        stamp_q.delete();
        q_nonempty = 8'h81;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd7);
        dq_ready = 1'b1;
        drain("wrap", 60);
        gap("wrap_gap", 0, 4);
        gap("wrap_reload_gap", 1, 6);
        cycles(6);

        // Reset mid-transfer
        auto_en = 1'b0;
        sp0_wrr1 = 1'b0;
        q_nonempty = 8'h08;
        exp_q.push_back(3'd3);
        dq_ready = 1'b1;
        drain("xfer_setup", 20);
        cycles(3);
        check("xfer_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_vld", grant_vld, 0);
        check("rst_mid_id", grant_id, 0);
        cycles(2);
        q_nonempty = '0;
        dq_ready = 1'b1;
        rst = 1'b1;
        stamp_q.delete();
        cycles(10);
        check("rst_no_grant", stamp_q.size(), 0);
        auto_en = 1'b1;
        q_nonempty = 8'h10;
        exp_q.push_back(3'd4);
        dq_ready = 1'b1;
        drain("post_rst", 20);
        cycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
